// File: rtl/jtbubl_rom_arb.sv
// jtbubl_rom_arb: SDRAM read arbiter for up to eight ROM slots, one cached 32-bit line per slot.
// Ports: clk/rst, downloading/loop_rst, slot_cs/addr/dout/ok, sdram_req/addr/ack, data_rdy/read, refresh_en.
module jtbubl_rom_arb #(
  parameter int                  SLOTS   = 5,
  parameter int                  AW      = 18,
  parameter logic [SLOTS*22-1:0] OFFSETS = '0,
  parameter logic [SLOTS-1:0]    DW32    = '0,
  parameter bit                  RR      = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic                loop_rst,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS*32-1:0] slot_dout,
  output logic [SLOTS-1:0]    slot_ok,
  output logic                sdram_req,
  output logic [21:0]         sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [31:0]         data_read,
  output logic                refresh_en
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DATA
  } state_t;

  state_t           state_q, state_d;
  logic [SLOTS-1:0] valid_q, valid_d;
  logic [AW-1:0]    tag_q  [SLOTS];
  logic [AW-1:0]    tag_d  [SLOTS];
  logic [31:0]      line_q [SLOTS];
  logic [31:0]      line_d [SLOTS];
  logic [IW-1:0]    win_q, win_d;
  logic [IW-1:0]    last_q, last_d;
  logic [AW-1:0]    wtag_q, wtag_d;
  logic [21:0]      addr_q, addr_d;
  logic             req_q, req_d;

  logic             hold;
  logic             blk;
  logic [AW-1:0]    tag_now [SLOTS];
  logic [21:0]      fetch   [SLOTS];
  logic [SLOTS-1:0] hit;
  logic [SLOTS-1:0] pend;
  logic             any_pend;
  logic [IW-1:0]    pick;
  logic             found;
  int               start;
  int               idx;

  assign blk  = downloading | loop_rst;
  assign hold = rst | blk;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    logic [AW-1:0] a;
    logic [21:0]   base;

    assign a = slot_addr[i*AW +: AW];

    if (DW32[i]) begin : g_w32
      assign tag_now[i] = a;
      assign base       = 22'({a, 1'b0});
      assign slot_dout[i*32 +: 32] = line_q[i];
    end else begin : g_w8
      logic [1:0] bsel;
      assign bsel       = a[1:0];
      assign tag_now[i] = AW'(a[AW-1:2]);
      assign base       = 22'({a[AW-1:2], 1'b0});
      assign slot_dout[i*32 +: 32] =
        {24'd0, line_q[i][{bsel, 3'b000} +: 8]};
    end

    assign fetch[i] = OFFSETS[i*22 +: 22] + base;
    assign hit[i]   = slot_cs[i] & valid_q[i]
                    & (tag_q[i] == tag_now[i]);
    // a blocked controller never reports misses
    assign pend[i]  = slot_cs[i] & ~hit[i] & ~hold;
  end

  assign slot_ok    = hit & {SLOTS{~hold}};
  assign any_pend   = |pend;
  assign refresh_en = (state_q == IDLE) & ~any_pend;
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

  // search starts at 0 for fixed priority, after the last grant otherwise
  always_comb begin
    pick  = '0;
    found = 1'b0;
    start = 0;
    idx   = 0;
    if (RR && (last_q != IW'(SLOTS-1))) begin
      start = int'(last_q) + 1;
    end
    for (int k = 0; k < SLOTS; k++) begin
      idx = (start + k) % SLOTS;
      if (!found && pend[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    line_d  = line_q;
    win_d   = win_q;
    last_d  = last_q;
    wtag_d  = wtag_q;
    addr_d  = addr_q;
    req_d   = req_q;
    if (blk) begin
      // abandon any transfer; its late data_rdy lands in IDLE
      state_d = IDLE;
      valid_d = '0;
      req_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_pend) begin
            win_d   = pick;
            last_d  = pick;
            wtag_d  = tag_now[pick];
            addr_d  = fetch[pick];
            req_d   = 1'b1;
            state_d = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            req_d   = 1'b0;
            state_d = WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          // tag comes from grant time, so a moved address misses again
          if (data_rdy) begin
            line_d[win_q]  = data_read;
            tag_d[win_q]   = wtag_q;
            valid_d[win_q] = 1'b1;
            state_d        = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      win_q   <= '0;
      last_q  <= IW'(SLOTS-1);
      wtag_q  <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        tag_q[i]  <= '0;
        line_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      win_q   <= win_d;
      last_q  <= last_d;
      wtag_q  <= wtag_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: tb/tb_jtbubl_rom_arb.sv
// tb_jtbubl_rom_arb: scenario tasks against two arbiter builds.
// dut0: fixed priority, slot1 32-bit at 0x20000; dut1: round-robin.
module tb_jtbubl_rom_arb;

  localparam int S  = 5;
  localparam int AW = 18;
  localparam logic [S*22-1:0] OFF0 = {66'd0, 22'h20000, 22'd0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            dl0, lr0, ack0, rdy0, req0, ref0;
  logic [S-1:0]    cs0, ok0;
  logic [S*AW-1:0] a0;
  logic [S*32-1:0] dout0;
  logic [21:0]     sa0;
  logic [31:0]     dr0;

  logic            dl1, lr1, ack1, rdy1, req1, ref1;
  logic [S-1:0]    cs1, ok1;
  logic [S*AW-1:0] a1;
  logic [S*32-1:0] dout1;
  logic [21:0]     sa1;
  logic [31:0]     dr1;

  int n_checks;
  int n_fail;
  logic [21:0] exp_q [$];

  jtbubl_rom_arb #(
    .SLOTS(S), .AW(AW), .OFFSETS(OFF0),
    .DW32(5'b00010), .RR(1'b0)
  ) u_dut0 (
    .clk(clk), .rst(rst),
    .downloading(dl0), .loop_rst(lr0),
    .slot_cs(cs0), .slot_addr(a0),
    .slot_dout(dout0), .slot_ok(ok0),
    .sdram_req(req0), .sdram_addr(sa0),
    .sdram_ack(ack0), .data_rdy(rdy0),
    .data_read(dr0), .refresh_en(ref0)
  );

  jtbubl_rom_arb #(
    .SLOTS(S), .AW(AW), .OFFSETS('0),
    .DW32(5'b00000), .RR(1'b1)
  ) u_dut1 (
    .clk(clk), .rst(rst),
    .downloading(dl1), .loop_rst(lr1),
    .slot_cs(cs1), .slot_addr(a1),
    .slot_dout(dout1), .slot_ok(ok1),
    .sdram_req(req1), .sdram_addr(sa1),
    .sdram_ack(ack1), .data_rdy(rdy1),
    .data_read(dr1), .refresh_en(ref1)
  );

  // SDRAM controller model: waits for req, acks, then returns data.
  task automatic sdram_txn(input bit sel, input logic [31:0] data,
                           input bit chg, input logic [AW-1:0] chg_a,
                           output bit got, output logic [21:0] seen);
    got  = 1'b0;
    seen = '0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if ((sel ? req1 : req0) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      seen = sel ? sa1 : sa0;
      if (sel) ack1 = 1'b1;
      else ack0 = 1'b1;
      @(negedge clk);
      ack0 = 1'b0;
      ack1 = 1'b0;
      if (chg) a0[AW-1:0] = chg_a;
      if (sel) begin
        rdy1 = 1'b1;
        dr1  = data;
      end else begin
        rdy0 = 1'b1;
        dr0  = data;
      end
      @(negedge clk);
      rdy0 = 1'b0;
      rdy1 = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (req0 !== 1'b0 || req1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req: got %b/%b want 0/0", req0, req1);
    end
    n_checks++;
    if (ok0 !== '0 || ok1 !== '0) begin
      n_fail++;
      $display("FAIL reset_ok: got %b/%b want 0", ok0, ok1);
    end
    n_checks++;
    if (dout0 !== '0 || dout1 !== '0) begin
      n_fail++;
      $display("FAIL reset_dout: got %h want 0", dout0);
    end
    n_checks++;
    if (sa0 !== 22'd0 || sa1 !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h/%h want 0", sa0, sa1);
    end
    n_checks++;
    if (ref0 !== 1'b1 || ref1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_refresh: got %b/%b want 1", ref0, ref1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_miss8();
    logic [21:0] e;
    cs0[0] = 1'b1;
    a0[0 +: AW] = 18'h5;
    exp_q.push_back(22'h000002);
    #1;
    n_checks++;
    if (ok0[0] !== 1'b0 || ref0 !== 1'b0) begin
      n_fail++;
      $display("FAIL miss8_pre: ok %b ref %b want 0 0", ok0[0], ref0);
    end
    @(negedge clk);
    n_checks++;
    if (req0 !== 1'b1) begin
      n_fail++;
      $display("FAIL miss8_latency: req %b want 1", req0);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (sa0 !== e) begin
      n_fail++;
      $display("FAIL miss8_addr: got %h want %h", sa0, e);
    end
    ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    n_checks++;
    if (req0 !== 1'b0 || ok0[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL miss8_ack: req %b ok %b want 0 0", req0, ok0[0]);
    end
    rdy0 = 1'b1;
    dr0  = 32'hDDCCBBAA;
    @(negedge clk);
    rdy0 = 1'b0;
    dr0  = '0;
    #1;
    n_checks++;
    if (ok0 !== 5'b00001 || dout0[31:0] !== 32'h000000BB) begin
      n_fail++;
      $display("FAIL miss8_fill: ok %b dout %h want 00001 000000bb",
               ok0, dout0[31:0]);
    end
    n_checks++;
    if (ref0 !== 1'b1) begin
      n_fail++;
      $display("FAIL miss8_refresh: got %b want 1", ref0);
    end
    a0[0 +: AW] = 18'h6;
    #1;
    n_checks++;
    if (ok0[0] !== 1'b1 || dout0[31:0] !== 32'h000000CC) begin
      n_fail++;
      $display("FAIL miss8_hit: ok %b dout %h want 1 000000cc",
               ok0[0], dout0[31:0]);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (req0 !== 1'b0) begin
      n_fail++;
      $display("FAIL miss8_norefetch: req %b want 0", req0);
    end
  endtask

  task automatic test_dw32();
    bit got;
    logic [21:0] seen, e;
    cs0 = 5'b00010;
    a0[1*AW +: AW] = 18'h10;
    exp_q.push_back(22'h020020);
    sdram_txn(1'b0, 32'hCAFEF00D, 1'b0, '0, got, seen);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || seen !== e) begin
      n_fail++;
      $display("FAIL dw32_addr: got %h (seen %b) want %h", seen, got, e);
    end
    #1;
    n_checks++;
    if (ok0 !== 5'b00010 || dout0[32 +: 32] !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL dw32_data: ok %b dout %h want 00010 cafef00d",
               ok0, dout0[32 +: 32]);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (req0 !== 1'b0 || ok0[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL dw32_stable: req %b ok %b want 0 1", req0, ok0[1]);
    end
  endtask

  task automatic test_priority();
    bit got;
    logic [21:0] seen, e;
    cs0 = 5'b01010;
    a0[1*AW +: AW] = 18'h20;
    a0[3*AW +: AW] = 18'h100;
    exp_q.push_back(22'h020040);
    exp_q.push_back(22'h000080);
    sdram_txn(1'b0, 32'h11112222, 1'b0, '0, got, seen);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || seen !== e) begin
      n_fail++;
      $display("FAIL prio_first: got %h want %h", seen, e);
    end
    #1;
    n_checks++;
    if (ok0[1] !== 1'b1 || ok0[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_ok1: ok %b want x1x1x pattern 01010 minus 3",
               ok0);
    end
    @(negedge clk);
    n_checks++;
    if (req0 !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_backtoback: req %b want 1", req0);
    end
    sdram_txn(1'b0, 32'hA1B2C3D4, 1'b0, '0, got, seen);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || seen !== e) begin
      n_fail++;
      $display("FAIL prio_second: got %h want %h", seen, e);
    end
    #1;
    n_checks++;
    if (ok0 !== 5'b01010 || dout0[3*32 +: 32] !== 32'h000000D4) begin
      n_fail++;
      $display("FAIL prio_fill3: ok %b dout %h want 01010 000000d4",
               ok0, dout0[3*32 +: 32]);
    end
  endtask

  task automatic test_addr_change();
    bit got;
    logic [21:0] seen, e;
    cs0 = 5'b00001;
    a0  = '0;
    a0[0 +: AW] = 18'h10;
    exp_q.push_back(22'h000008);
    exp_q.push_back(22'h000010);
    sdram_txn(1'b0, 32'h44332211, 1'b1, 18'h20, got, seen);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || seen !== e) begin
      n_fail++;
      $display("FAIL move_first: got %h want %h", seen, e);
    end
    #1;
    n_checks++;
    if (ok0[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL move_nohit: ok %b want 0", ok0[0]);
    end
    a0[0 +: AW] = 18'h13;
    #1;
    n_checks++;
    if (ok0[0] !== 1'b1 || dout0[31:0] !== 32'h00000044) begin
      n_fail++;
      $display("FAIL move_oldtag: ok %b dout %h want 1 00000044",
               ok0[0], dout0[31:0]);
    end
    a0[0 +: AW] = 18'h20;
    @(negedge clk);
    n_checks++;
    if (req0 !== 1'b1) begin
      n_fail++;
      $display("FAIL move_rereq: req %b want 1", req0);
    end
    sdram_txn(1'b0, 32'h88776655, 1'b0, '0, got, seen);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || seen !== e) begin
      n_fail++;
      $display("FAIL move_second: got %h want %h", seen, e);
    end
    #1;
    n_checks++;
    if (ok0[0] !== 1'b1 || dout0[31:0] !== 32'h00000055) begin
      n_fail++;
      $display("FAIL move_fill: ok %b dout %h want 1 00000055",
               ok0[0], dout0[31:0]);
    end
  endtask

  task automatic test_download();
    bit got;
    logic [21:0] seen, e;
    cs0 = 5'b00101;
    a0[2*AW +: AW] = 18'h40;
    exp_q.push_back(22'h000020);
    #1;
    n_checks++;
    if (ok0[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL dl_prehit: ok %b want 1", ok0[0]);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (req0 !== 1'b1 || sa0 !== e) begin
      n_fail++;
      $display("FAIL dl_req: req %b addr %h want 1 %h", req0, sa0, e);
    end
    dl0 = 1'b1;
    #1;
    n_checks++;
    if (ok0 !== '0) begin
      n_fail++;
      $display("FAIL dl_okgate: ok %b want 0", ok0);
    end
    @(negedge clk);
    n_checks++;
    if (req0 !== 1'b0 || ok0 !== '0) begin
      n_fail++;
      $display("FAIL dl_abort: req %b ok %b want 0 0", req0, ok0);
    end
    ack0 = 1'b1;
    rdy0 = 1'b1;
    dr0  = 32'hDEADBEEF;
    @(negedge clk);
    ack0 = 1'b0;
    cs0  = '0;
    dl0  = 1'b0;
    @(negedge clk);
    rdy0 = 1'b0;
    n_checks++;
    if (req0 !== 1'b0) begin
      n_fail++;
      $display("FAIL dl_late: req %b want 0", req0);
    end
    cs0 = 5'b00100;
    #1;
    n_checks++;
    if (ok0[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL dl_novalid: ok %b want 0", ok0[2]);
    end
    exp_q.push_back(22'h000020);
    sdram_txn(1'b0, 32'h0A0B0C0D, 1'b0, '0, got, seen);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || seen !== e) begin
      n_fail++;
      $display("FAIL dl_refetch: got %h want %h", seen, e);
    end
    #1;
    n_checks++;
    if (ok0 !== 5'b00100 || dout0[2*32 +: 32] !== 32'h0000000D) begin
      n_fail++;
      $display("FAIL dl_fill: ok %b dout %h want 00100 0000000d",
               ok0, dout0[2*32 +: 32]);
    end
    cs0[0] = 1'b1;
    #1;
    n_checks++;
    if (ok0[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL dl_cleared: ok %b want 0", ok0[0]);
    end
    exp_q.push_back(22'h000010);
    sdram_txn(1'b0, 32'h00000099, 1'b0, '0, got, seen);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || seen !== e) begin
      n_fail++;
      $display("FAIL dl_slot0: got %h want %h", seen, e);
    end
    lr0 = 1'b1;
    #1;
    n_checks++;
    if (ok0 !== '0) begin
      n_fail++;
      $display("FAIL lr_okgate: ok %b want 0", ok0);
    end
    @(negedge clk);
    lr0 = 1'b0;
    cs0 = 5'b00100;
    #1;
    n_checks++;
    if (ok0[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL lr_cleared: ok %b want 0", ok0[2]);
    end
    cs0 = '0;
    @(negedge clk);
    n_checks++;
    if (req0 !== 1'b0 || ref0 !== 1'b1) begin
      n_fail++;
      $display("FAIL lr_idle: req %b ref %b want 0 1", req0, ref0);
    end
  endtask

  task automatic test_rr();
    bit got;
    logic [21:0] seen, e;
    cs1 = 5'b00111;
    a1[0*AW +: AW] = 18'h100;
    a1[1*AW +: AW] = 18'h200;
    a1[2*AW +: AW] = 18'h300;
    exp_q.push_back(22'h000080);
    exp_q.push_back(22'h000100);
    exp_q.push_back(22'h000180);
    exp_q.push_back(22'h000200);
    sdram_txn(1'b1, 32'h000000A0, 1'b0, '0, got, seen);
    a1[0*AW +: AW] = 18'h400;
    e = exp_q.pop_front();
    n_checks++;
    if (!got || seen !== e) begin
      n_fail++;
      $display("FAIL rr_grant0: got %h want %h", seen, e);
    end
    for (int g = 1; g < 4; g++) begin
      sdram_txn(1'b1, 32'h000000A0 + g, 1'b0, '0, got, seen);
      e = exp_q.pop_front();
      n_checks++;
      if (!got || seen !== e) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %h want %h", g, seen, e);
      end
    end
    #1;
    n_checks++;
    if (ok1[2:0] !== 3'b111 || dout1[31:0] !== 32'h000000A3) begin
      n_fail++;
      $display("FAIL rr_final: ok %b dout %h want 111 000000a3",
               ok1[2:0], dout1[31:0]);
    end
    cs1 = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_wait_data();
    logic [21:0] e;
    cs0 = 5'b10000;
    a0[4*AW +: AW] = 18'h8;
    exp_q.push_back(22'h000004);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (req0 !== 1'b1 || sa0 !== e) begin
      n_fail++;
      $display("FAIL rstwd_req: req %b addr %h want 1 %h", req0, sa0, e);
    end
    ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    rst  = 1'b1;
    cs0  = '0;
    @(negedge clk);
    n_checks++;
    if (req0 !== 1'b0 || sa0 !== 22'd0 || ref0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rstwd_ctl: req %b addr %h ref %b want 0 0 1",
               req0, sa0, ref0);
    end
    n_checks++;
    if (ok0 !== '0 || dout0 !== '0) begin
      n_fail++;
      $display("FAIL rstwd_data: ok %b dout %h want 0", ok0, dout0);
    end
    rst  = 1'b0;
    rdy0 = 1'b1;
    dr0  = 32'h5A5A5A5A;
    @(negedge clk);
    rdy0 = 1'b0;
    cs0  = 5'b10000;
    #1;
    n_checks++;
    if (ok0[4] !== 1'b0 || dout0 !== '0) begin
      n_fail++;
      $display("FAIL rstwd_nofill: ok %b dout %h want 0 0", ok0[4], dout0);
    end
    cs0 = '0;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    dl0  = 1'b0; lr0 = 1'b0; cs0 = '0; a0 = '0;
    ack0 = 1'b0; rdy0 = 1'b0; dr0 = '0;
    dl1  = 1'b0; lr1 = 1'b0; cs1 = '0; a1 = '0;
    ack1 = 1'b0; rdy1 = 1'b0; dr1 = '0;
    test_reset();
    test_miss8();
    test_dw32();
    test_priority();
    test_addr_change();
    test_download();
    test_rr();
    test_reset_wait_data();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
